approx_mult_error_scanner: RTL and testbench



---
 rtl/approx_mult_eval_pkg.sv | 19 +
 rtl/error_accumulator.sv | 63 ++++++
 rtl/approx_mult_error_scanner.sv | 109 ++++++++++
 tb/tb_approx_mult_error_scanner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_eval_pkg.sv
// Shared types and constants for the approximate-multiplier error scanner.
package approx_mult_eval_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int unsigned N_PAIRS      = 65536;
    localparam int unsigned DRAIN_CYCLES = 2;

    localparam int unsigned ERR_CNT_W = 17;
    localparam int unsigned SUM_ABS_W = 32;
    localparam int unsigned SUM_SQ_W  = 48;
    localparam int unsigned MAX_ABS_W = 16;

endpackage

// File: rtl/error_accumulator.sv
// S2/S3 of the scanner pipeline: absolute error and its square, then the
// running count, sums and maximum.
module error_accumulator
    import approx_mult_eval_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   valid,
    input  logic [WIDTH-1:0]       x,
    input  logic [WIDTH-1:0]       y,
    input  logic [2*WIDTH-1:0]     z,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [SUM_ABS_W-1:0]   sum_abs_err,
    output logic [SUM_SQ_W-1:0]    sum_sq_err,
    output logic [MAX_ABS_W-1:0]   max_abs_err
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = 2 * PW;

    logic [PW-1:0] exact;
    logic [PW-1:0] abs_d;
    logic [PW-1:0] abs_q;
    logic [SW-1:0] sq_q;
    logic          valid_q;

    // |z - x*y| taken on unsigned operands; equivalent to the 17-bit signed diff.
    always_comb begin
        exact = PW'(x) * PW'(y);
        abs_d = (z >= exact) ? (z - exact) : (exact - z);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_q <= 1'b0;
            abs_q   <= '0;
            sq_q    <= '0;
        end else begin
            valid_q <= valid;
            abs_q   <= abs_d;
            sq_q    <= SW'(abs_d) * SW'(abs_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            max_abs_err <= '0;
        end else if (valid_q) begin
            err_cnt     <= err_cnt + ERR_CNT_W'(abs_q != '0);
            sum_abs_err <= sum_abs_err + SUM_ABS_W'(abs_q);
            sum_sq_err  <= sum_sq_err + SUM_SQ_W'(sq_q);
            if (MAX_ABS_W'(abs_q) > max_abs_err)
                max_abs_err <= MAX_ABS_W'(abs_q);
        end
    end

endmodule

// File: rtl/approx_mult_error_scanner.sv
// Exhaustive operand sweep around an external combinational multiplier,
// accumulating error statistics against the exact product.
module approx_mult_error_scanner
    import approx_mult_eval_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       x,
    output logic [WIDTH-1:0]       y,
    input  logic [2*WIDTH-1:0]     z,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [SUM_ABS_W-1:0]   sum_abs_err,
    output logic [SUM_SQ_W-1:0]    sum_sq_err,
    output logic [MAX_ABS_W-1:0]   max_abs_err
);

    localparam int unsigned CW    = 2 * WIDTH;
    // Sweep length scales down from N_PAIRS for narrower operands.
    localparam int unsigned PAIRS = N_PAIRS >> (2 * (8 - WIDTH));
    localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        drain_q;
    logic              launch;
    logic [WIDTH-1:0]  x_s1, y_s1;
    logic [CW-1:0]     z_s1;
    logic              v_s1;

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        x       = '0;
        y       = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                busy = 1'b1;
                x    = cnt_q[WIDTH-1:0];
                y    = cnt_q[CW-1:WIDTH];
                if (cnt_q == LAST)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q == 2'(DRAIN_CYCLES - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    launch  = 1'b1;
                    state_d = S_SWEEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
            v_s1    <= 1'b0;
            x_s1    <= '0;
            y_s1    <= '0;
            z_s1    <= '0;
        end else begin
            state_q <= state_d;
            if (launch)
                cnt_q <= '0;
            else if (state_q == S_SWEEP)
                cnt_q <= cnt_q + 1'b1;
            drain_q <= (state_q == S_DRAIN) ? drain_q + 1'b1 : '0;
            v_s1    <= (state_q == S_SWEEP);
            x_s1    <= x;
            y_s1    <= y;
            z_s1    <= z;
        end
    end

    error_accumulator #(.WIDTH(WIDTH)) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (launch),
        .valid       (v_s1),
        .x           (x_s1),
        .y           (y_s1),
        .z           (z_s1),
        .err_cnt     (err_cnt),
        .sum_abs_err (sum_abs_err),
        .sum_sq_err  (sum_sq_err),
        .max_abs_err (max_abs_err)
    );

endmodule

// File: tb/tb_approx_mult_error_scanner.sv
// Directed bench for approx_mult_error_scanner with behavioural multiplier models.
module tb_approx_mult_error_scanner;

    localparam int M_EXACT = 0;
    localparam int M_PLUS1 = 1;
    localparam int M_ZERO  = 2;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // Full-width instance
    logic        start8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] z8;
    logic [16:0] err8;
    logic [31:0] abs8;
    logic [47:0] sq8;
    logic [15:0] max8;
    int          mode8;

    always_comb begin
        case (mode8)
            M_EXACT: z8 = 16'(x8) * 16'(y8);
            M_PLUS1: z8 = 16'(x8) * 16'(y8) + 16'd1;
            default: z8 = '0;
        endcase
    end

    approx_mult_error_scanner #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
        .x(x8), .y(y8), .z(z8),
        .err_cnt(err8), .sum_abs_err(abs8), .sum_sq_err(sq8), .max_abs_err(max8)
    );

    // Narrow instance
    logic        start4, busy4, done4;
    logic [3:0]  x4, y4;
    logic [7:0]  z4;
    logic [16:0] err4;
    logic [31:0] abs4;
    logic [47:0] sq4;
    logic [15:0] max4;
    int          mode4;

    always_comb begin
        case (mode4)
            M_EXACT: z4 = 8'(x4) * 8'(y4);
            M_PLUS1: z4 = 8'(x4) * 8'(y4) + 8'd1;
            default: z4 = '0;
        endcase
    end

    approx_mult_error_scanner #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .x(x4), .y(y4), .z(z4),
        .err_cnt(err4), .sum_abs_err(abs4), .sum_sq_err(sq4), .max_abs_err(max4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic stats8(input string p, input logic [63:0] e_err, input logic [63:0] e_abs,
                          input logic [63:0] e_sq, input logic [63:0] e_max);
        check({p, ".err_cnt"},     err8, e_err);
        check({p, ".sum_abs_err"}, abs8, e_abs);
        check({p, ".sum_sq_err"},  sq8,  e_sq);
        check({p, ".max_abs_err"}, max8, e_max);
    endtask

    task automatic stats4(input string p, input logic [63:0] e_err, input logic [63:0] e_abs,
                          input logic [63:0] e_sq, input logic [63:0] e_max);
        check({p, ".err_cnt"},     err4, e_err);
        check({p, ".sum_abs_err"}, abs4, e_abs);
        check({p, ".sum_sq_err"},  sq4,  e_sq);
        check({p, ".max_abs_err"}, max4, e_max);
    endtask

    task automatic run8(input string p);
        int n;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({p, ".busy_at_start"}, busy8, 1);
        check({p, ".done_at_start"}, done8, 0);
        check({p, ".x_first"}, x8, 0);
        check({p, ".y_first"}, y8, 0);
        n = 0;
        while (done8 !== 1'b1 && n < 70000) begin
            tick();
            n++;
            if (n == 'h1234) begin
                check({p, ".x_mid"}, x8, 8'h34);
                check({p, ".y_mid"}, y8, 8'h12);
            end
        end
        check({p, ".done_latency"}, n, 65538);
        check({p, ".busy_at_done"}, busy8, 0);
        check({p, ".x_at_done"}, x8, 0);
    endtask

    task automatic run4(input string p, input bit pulse);
        int n;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check({p, ".busy_at_start"}, busy4, 1);
        check({p, ".done_at_start"}, done4, 0);
        check({p, ".x_first"}, x4, 0);
        check({p, ".y_first"}, y4, 0);
        n = 0;
        while (done4 !== 1'b1 && n < 400) begin
            tick();
            n++;
            start4 = pulse && (n == 20 || n == 21 || n == 150);
            if (n == 'h5A) begin
                check({p, ".x_mid"}, x4, 4'hA);
                check({p, ".y_mid"}, y4, 4'h5);
            end
        end
        start4 = 1'b0;
        check({p, ".done_latency"}, n, 258);
        check({p, ".busy_at_done"}, busy4, 0);
        check({p, ".x_at_done"}, x4, 0);
        check({p, ".y_at_done"}, y4, 0);
    endtask

    initial begin
        rst    = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        mode8  = M_ZERO;
        mode4  = M_EXACT;
        repeat (3) tick();
        check("reset.busy", busy8, 0);
        check("reset.done", done8, 0);
        check("reset.x", x8, 0);
        check("reset.y", y8, 0);
        stats8("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check("idle.busy", busy8, 0);

        run8("w8_zero");
        stats8("w8_zero", 65025, 1065369600, 64'd30910041702400, 65025);
        tick();
        check("w8_zero.done_holds", done8, 1);
        stats8("w8_zero_hold", 65025, 1065369600, 64'd30910041702400, 65025);

        run4("w4_exact", 1'b0);
        stats4("w4_exact", 0, 0, 0, 0);

        mode4 = M_ZERO;
        check("w4_b2b.done_before", done4, 1);
        run4("w4_zero", 1'b0);
        stats4("w4_zero", 225, 14400, 1537600, 225);

        mode4 = M_PLUS1;
        run4("w4_plus1", 1'b0);
        stats4("w4_plus1", 256, 256, 256, 1);

        run4("w4_pulse", 1'b1);
        stats4("w4_pulse", 256, 256, 256, 1);

        mode4  = M_ZERO;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        check("abort.busy", busy4, 0);
        check("abort.done", done4, 0);
        check("abort.x", x4, 0);
        check("abort.y", y4, 0);
        stats4("abort", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        run4("w4_rerun", 1'b0);
        stats4("w4_rerun", 225, 14400, 1537600, 225);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
